// File: rtl/otter_crypto_unit.sv
// OTTER ENCRY engine: one cipher round per clock with an on-the-fly key schedule.
// Optional decrypt round-key cache is enabled by defining CRYPTO_KEYCACHE_EN.
module otter_crypto_unit #(
  parameter  int ROUNDS = 4,
  parameter  int ROT    = 5,
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          CRY_CLK,
  input  logic          CRY_RST_N,
  input  logic          CRY_START,
  input  logic          CRY_DECRYPT,
  input  logic [31:0]   CRY_KEY,
  input  logic [31:0]   CRY_DATA_IN,
  output logic          CRY_BUSY,
  output logic          CRY_DONE,
  output logic [31:0]   CRY_DATA_OUT,
  output logic [RW-1:0] CRY_ROUND
);

  typedef enum logic [1:0] {S_IDLE, S_KEYGEN, S_ROUND, S_DONE} state_t;

  localparam logic [31:0]   RC_BASE     = 32'h9E3779B9;
  localparam logic [RW-1:0] KEYGEN_LAST = RW'(ROUNDS - 2);
  localparam logic [RW-1:0] ROUND_LAST  = RW'(ROUNDS - 1);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] rc(input logic [RW-1:0] i);
    return RC_BASE ^ 32'(i);
  endfunction

  state_t        r_state;
  logic          r_dec;
  logic [RW-1:0] r_cnt;
  logic [31:0]   r_s;
  logic [31:0]   r_rk;
  logic [31:0]   r_data_out;
  logic          r_busy;
  logic          r_done;

  logic [31:0] w_rk_fwd;
  logic [31:0] w_rk_inv;
  logic [31:0] w_s_enc;
  logic [31:0] w_s_dec;
  logic [31:0] w_s_next;
  logic [31:0] w_start_rk;
  logic        w_accept;
  logic        w_cache_hit;
  logic        w_keygen_end;

  // Decrypt walks the schedule backwards: round j holds rk(ROUNDS-1-j) and
  // steps to rk(ROUNDS-2-j), so the inverse uses RC(KEYGEN_LAST - cnt).
  assign w_rk_fwd     = rotl(r_rk, 8) ^ rc(r_cnt);
  assign w_rk_inv     = rotr(r_rk ^ rc(KEYGEN_LAST - r_cnt), 8);
  assign w_s_enc      = rotl(r_s ^ r_rk, ROT) + r_rk;
  assign w_s_dec      = rotr(r_s - r_rk, ROT) ^ r_rk;
  assign w_s_next     = r_dec ? w_s_dec : w_s_enc;
  assign w_accept     = CRY_START && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_keygen_end = (r_state == S_KEYGEN) && (r_cnt == KEYGEN_LAST);

`ifdef CRYPTO_KEYCACHE_EN
  logic        r_cache_vld;
  logic [31:0] r_cache_key;
  logic [31:0] r_cache_rk;
  logic [31:0] r_key;

  assign w_cache_hit = CRY_DECRYPT && r_cache_vld && (CRY_KEY == r_cache_key);
  assign w_start_rk  = w_cache_hit ? r_cache_rk : CRY_KEY;

  // r_key remembers the base key because r_rk is overwritten during KEYGEN.
  always_ff @(posedge CRY_CLK or negedge CRY_RST_N) begin
    if (!CRY_RST_N) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= '0;
      r_cache_rk  <= '0;
      r_key       <= '0;
    end else begin
      if (w_accept) r_key <= CRY_KEY;
      if (w_keygen_end) begin
        r_cache_vld <= 1'b1;
        r_cache_key <= r_key;
        r_cache_rk  <= w_rk_fwd;
      end
    end
  end
`else
  assign w_cache_hit = 1'b0;
  assign w_start_rk  = CRY_KEY;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking would chain updates within one edge.
  always_ff @(posedge CRY_CLK or negedge CRY_RST_N) begin
    if (!CRY_RST_N) begin
      r_state    <= S_IDLE;
      r_dec      <= 1'b0;
      r_cnt      <= '0;
      r_s        <= '0;
      r_rk       <= '0;
      r_data_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (w_accept) begin
            r_s     <= CRY_DATA_IN;
            r_rk    <= w_start_rk;
            r_dec   <= CRY_DECRYPT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= (CRY_DECRYPT && !w_cache_hit) ? S_KEYGEN : S_ROUND;
          end
        end
        S_KEYGEN: begin
          r_rk <= w_rk_fwd;
          if (w_keygen_end) begin
            r_cnt   <= '0;
            r_state <= S_ROUND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ROUND: begin
          r_s  <= w_s_next;
          r_rk <= r_dec ? w_rk_inv : w_rk_fwd;
          if (r_cnt == ROUND_LAST) begin
            r_data_out <= w_s_next;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CRY_BUSY     = r_busy;
  assign CRY_DONE     = r_done;
  assign CRY_DATA_OUT = r_data_out;
  assign CRY_ROUND    = r_cnt;

endmodule

// File: tb/tb_otter_crypto_unit.sv
// Self-checking bench for otter_crypto_unit: directed steps plus random round trips
// checked against a loop-based cipher model; key-cache latency follows CRYPTO_KEYCACHE_EN.
module tb_otter_crypto_unit;

  localparam int ROUNDS   = 4;
  localparam int ROT      = 5;
  localparam int RW       = $clog2(ROUNDS);
  localparam int MAX_WAIT = 20;

`ifdef CRYPTO_KEYCACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic          CRY_CLK;
  logic          CRY_RST_N;
  logic          CRY_START;
  logic          CRY_DECRYPT;
  logic [31:0]   CRY_KEY;
  logic [31:0]   CRY_DATA_IN;
  logic          CRY_BUSY;
  logic          CRY_DONE;
  logic [31:0]   CRY_DATA_OUT;
  logic [RW-1:0] CRY_ROUND;

  int          checks = 0;
  int          errors = 0;
  bit          cache_vld;
  logic [31:0] cache_key;
  logic [31:0] last_trace;

  otter_crypto_unit #(.ROUNDS(ROUNDS), .ROT(ROT)) dut (
    .CRY_CLK      (CRY_CLK),
    .CRY_RST_N    (CRY_RST_N),
    .CRY_START    (CRY_START),
    .CRY_DECRYPT  (CRY_DECRYPT),
    .CRY_KEY      (CRY_KEY),
    .CRY_DATA_IN  (CRY_DATA_IN),
    .CRY_BUSY     (CRY_BUSY),
    .CRY_DONE     (CRY_DONE),
    .CRY_DATA_OUT (CRY_DATA_OUT),
    .CRY_ROUND    (CRY_ROUND)
  );

  initial begin
    CRY_CLK = 1'b0;
    forever #5 CRY_CLK = ~CRY_CLK;
  end

  // Rotation via a doubled word, then keep the low 32 bits.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> (32 - n);
    return dbl[31:0];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return rotl32(x, 32 - n);
  endfunction

  function automatic logic [31:0] model(input logic dec, input logic [31:0] key,
                                        input logic [31:0] data);
    logic [31:0] rk [ROUNDS];
    logic [31:0] s;
    rk[0] = key;
    for (int i = 1; i < ROUNDS; i++)
      rk[i] = rotl32(rk[i-1], 8) ^ (32'h9E3779B9 ^ 32'(i - 1));
    s = data;
    for (int i = 0; i < ROUNDS; i++) begin
      if (!dec) s = rotl32(s ^ rk[i], ROT) + rk[i];
      else      s = rotr32(s - rk[ROUNDS-1-i], ROT) ^ rk[ROUNDS-1-i];
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_trace(input bit with_keygen);
    logic [31:0] t;
    t = '0;
    if (with_keygen)
      for (int i = 0; i < ROUNDS - 1; i++) t = (t << RW) | 32'(i);
    for (int i = 0; i < ROUNDS; i++) t = (t << RW) | 32'(i);
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CRY_CLK);
    #1;
  endtask

  // Issues one START and waits for DONE; leaves the bench in the DONE-high cycle.
  task automatic run_op(input string tag, input logic dec, input logic [31:0] key,
                        input logic [31:0] data, input bit inject,
                        output logic [31:0] result);
    bit          hit;
    int          exp_lat, lat, busy_cyc, changes;
    logic [31:0] exp_res, held;
    hit     = CACHE_EN && dec && cache_vld && (key == cache_key);
    exp_lat = (dec && !hit) ? 2 * ROUNDS - 1 : ROUNDS;
    exp_res = model(dec, key, data);
    held    = CRY_DATA_OUT;
    CRY_START = 1'b1; CRY_DECRYPT = dec; CRY_KEY = key; CRY_DATA_IN = data;
    tick();
    CRY_START = 1'b0; CRY_DECRYPT = 1'($urandom); CRY_KEY = $urandom; CRY_DATA_IN = $urandom;
    check({tag, "_busy_after_start"}, 32'(CRY_BUSY), 32'd1);
    lat = 0; busy_cyc = 0; changes = 0; last_trace = '0;
    while (!CRY_DONE && lat < MAX_WAIT) begin
      if (CRY_BUSY) begin
        busy_cyc++;
        last_trace = (last_trace << RW) | 32'(CRY_ROUND);
      end
      if (CRY_DATA_OUT !== held) changes++;
      CRY_START = inject && (lat == 1);
      if (CRY_START) begin
        CRY_DATA_IN = ~data; CRY_KEY = ~key; CRY_DECRYPT = ~dec;
      end
      tick();
      CRY_START = 1'b0;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
    check({tag, "_out_held"}, 32'(changes), 32'd0);
    check({tag, "_data_out"}, CRY_DATA_OUT, exp_res);
    result = CRY_DATA_OUT;
    if (CACHE_EN && dec && !hit) begin
      cache_vld = 1'b1;
      cache_key = key;
    end
  endtask

  task automatic idle_check(input string tag, input logic [31:0] held);
    tick();
    check({tag, "_done_pulse"}, 32'(CRY_DONE), 32'd0);
    check({tag, "_out_after_done"}, CRY_DATA_OUT, held);
  endtask

  initial begin
    logic [31:0] ct, pt, k1, d1, r1, r2;
    logic        dec;
    int          done_seen;

    CRY_RST_N = 1'b0; CRY_START = 1'b0; CRY_DECRYPT = 1'b0;
    CRY_KEY = '0; CRY_DATA_IN = '0;
    cache_vld = 1'b0; cache_key = '0;
    #12;
    check("rst_busy", 32'(CRY_BUSY), 32'd0);
    check("rst_done", 32'(CRY_DONE), 32'd0);
    check("rst_data_out", CRY_DATA_OUT, 32'd0);
    check("rst_round", 32'(CRY_ROUND), 32'd0);
    CRY_RST_N = 1'b1;
    tick();
    tick();

    // Directed encrypt then decrypt round trip.
    run_op("enc_dir", 1'b0, 32'h01234567, 32'hDEADBEEF, 1'b0, ct);
    check("enc_dir_trace", last_trace, exp_trace(1'b0));
    idle_check("enc_dir", ct);
    run_op("dec_dir", 1'b1, 32'h01234567, ct, 1'b0, pt);
    check("dec_dir_trace", last_trace, exp_trace(1'b1));
    check("dec_dir_roundtrip", pt, 32'hDEADBEEF);
    idle_check("dec_dir", pt);

    // Repeat decrypt with same key (cache hit when enabled), then a new key.
    run_op("dec_rep", 1'b1, 32'h01234567, ct, 1'b0, pt);
    check("dec_rep_roundtrip", pt, 32'hDEADBEEF);
    idle_check("dec_rep", pt);
    run_op("dec_newkey", 1'b1, 32'h01234566, ct, 1'b0, pt);
    idle_check("dec_newkey", pt);

    // START while busy must be ignored.
    k1 = $urandom; d1 = $urandom;
    run_op("enc_ignore", 1'b0, k1, d1, 1'b1, ct);
    idle_check("enc_ignore", ct);

    // Back-to-back: second START lands in the DONE cycle.
    run_op("b2b_enc", 1'b0, k1, d1, 1'b0, ct);
    run_op("b2b_dec", 1'b1, k1, ct, 1'b0, pt);
    check("b2b_roundtrip", pt, d1);
    idle_check("b2b", pt);

    // Random round trips in both directions.
    for (int n = 0; n < 6; n++) begin
      k1  = $urandom;
      d1  = $urandom;
      dec = 1'($urandom);
      run_op("rnd_a", dec, k1, d1, 1'b0, r1);
      run_op("rnd_b", ~dec, k1, r1, 1'b0, r2);
      check("rnd_roundtrip", r2, d1);
      if (n[0]) idle_check("rnd", r2);
    end

    // Asynchronous reset in the middle of ROUND.
    CRY_START = 1'b1; CRY_DECRYPT = 1'b0; CRY_KEY = $urandom; CRY_DATA_IN = $urandom;
    tick();
    CRY_START = 1'b0;
    tick();
    tick();
    #2 CRY_RST_N = 1'b0;
    #1;
    check("arst_busy", 32'(CRY_BUSY), 32'd0);
    check("arst_done", 32'(CRY_DONE), 32'd0);
    check("arst_data_out", CRY_DATA_OUT, 32'd0);
    check("arst_round", 32'(CRY_ROUND), 32'd0);
    cache_vld = 1'b0;
    repeat (2) tick();
    #3 CRY_RST_N = 1'b1;
    done_seen = 0;
    repeat (12) begin
      tick();
      if (CRY_DONE) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    check("arst_idle_busy", 32'(CRY_BUSY), 32'd0);

    k1 = $urandom; d1 = $urandom;
    run_op("post_rst_enc", 1'b0, k1, d1, 1'b0, ct);
    run_op("post_rst_dec", 1'b1, k1, ct, 1'b0, pt);
    check("post_rst_roundtrip", pt, d1);
    idle_check("post_rst", pt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
